// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling of a synchronized line, byte presented
// on a valid/ack hold interface with single-cycle framing-error and overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       rx_i,
  input  logic       rx_ack_i,
  output logic [7:0] data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bitIdx;
  logic [7:0]      r_shreg;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_frameErr;
  logic            r_overrun;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_rxPrev;
  logic            w_rxS;
  logic            w_startEdge;

  // Synchronizer and edge-history flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_sync1  <= rx_i;
      r_sync2  <= r_sync1;
      r_rxPrev <= r_sync2;
    end
  end

  assign w_rxS       = r_sync2;
  assign w_startEdge = r_rxPrev & ~r_sync2;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bitIdx   <= '0;
      r_shreg    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
      // A stop-bit load later in this block overrides the ack clear.
      if (rx_ack_i && r_valid) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_startEdge) begin
            r_cnt   <= '0;
            r_state <= START;
          end
        end
        START: begin
          if (r_cnt == HALF_LAST) begin
            if (w_rxS) begin
              r_state <= IDLE;
            end else begin
              r_state  <= DATA;
              r_cnt    <= '0;
              r_bitIdx <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_shreg[r_bitIdx] <= w_rxS;
            r_cnt             <= '0;
            if (r_bitIdx == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            if (!w_rxS) begin
              r_frameErr <= 1'b1;
            end else if (r_valid && !rx_ack_i) begin
              r_overrun <= 1'b1;
            end else begin
              r_data  <= r_shreg;
              r_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_o      = r_data;
  assign rx_valid_o  = r_valid;
  assign frame_err_o = r_frameErr;
  assign overrun_o   = r_overrun;
  assign busy_o      = (r_state != IDLE);

endmodule
